// File: rtl/mag_search.sv
// mag_search: successive-approximation search engine.
// Drives the A operand of a magnitude comparator and recovers the unknown
// B operand (target) by MSB-first binary search, using the comparator's
// less/equal/greater flags. Reports done, result and a flag-consistency error.
module mag_search #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  output logic [WIDTH-1:0] guess,
  input  logic             less,
  input  logic             equal,
  input  logic             greater,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             err
);

  localparam int IDX_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;

  localparam logic [0:0] S_IDLE  = 1'b0;
  localparam logic [0:0] S_PROBE = 1'b1;

  localparam logic [WIDTH-1:0] MSB_PROBE = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic [IDX_W-1:0] IDX_TOP   = IDX_W'(WIDTH-1);

  logic [0:0]       state;
  logic [WIDTH-1:0] acc;        // bits confirmed so far
  logic [IDX_W-1:0] idx;        // bit position currently under trial

  logic             flags_ok;
  logic [WIDTH-1:0] acc_next;
  logic [IDX_W-1:0] idx_dec;
  logic [WIDTH-1:0] probe_next;

  assign busy = (state == S_PROBE);

  // Decode the comparator answer for the current probe and form the next probe.
  always_comb begin
    // NOTE: every signal gets a default first so no path can infer a latch.
    flags_ok   = 1'b0;
    acc_next   = acc;
    idx_dec    = idx;
    probe_next = guess;

    flags_ok   = $onehot({less, equal, greater});
    // guess < target means the trial bit belongs to the target: keep it.
    acc_next   = less ? guess : acc;
    // Only consumed when idx != 0, so the decrement never wraps in use.
    idx_dec    = idx - IDX_W'(1);
    probe_next = acc_next | (WIDTH'(1) << idx_dec);
  end

  // Search sequencer: IDLE waits for start, PROBE evaluates one bit per cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= S_IDLE;
      guess  <= '0;
      acc    <= '0;
      idx    <= IDX_TOP;
      done   <= 1'b0;
      result <= '0;
      err    <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            acc   <= '0;
            idx   <= IDX_TOP;
            guess <= MSB_PROBE;
            err   <= 1'b0;
            state <= S_PROBE;
          end
        end
        S_PROBE: begin
          if (!flags_ok) begin
            // Comparator answered inconsistently: abort with an error.
            err    <= 1'b1;
            result <= '0;
            done   <= 1'b1;
            state  <= S_IDLE;
          end else if (equal) begin
            // Exact hit: no need to try the remaining lower bits.
            result <= guess;
            done   <= 1'b1;
            state  <= S_IDLE;
          end else begin
            acc <= acc_next;
            if (idx == '0) begin
              result <= acc_next;
              done   <= 1'b1;
              state  <= S_IDLE;
            end else begin
              idx   <= idx_dec;
              guess <= probe_next;
            end
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mag_search.sv
// tb_mag_search: self-checking bench for mag_search (WIDTH=4).
// A behavioural comparator answers the DUT's probes; the expected probe
// sequence, probe count and result are derived arithmetically from the target.
module tb_mag_search;

  localparam int WIDTH = 4;

  logic             clk;
  logic             rst_n;
  logic             start;
  logic [WIDTH-1:0] guess;
  logic             less;
  logic             equal;
  logic             greater;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] result;
  logic             err;

  logic [WIDTH-1:0] target;
  logic             fault;

  int n_checks = 0;
  int n_fail   = 0;

  mag_search #(.WIDTH(WIDTH)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (start),
    .guess   (guess),
    .less    (less),
    .equal   (equal),
    .greater (greater),
    .busy    (busy),
    .done    (done),
    .result  (result),
    .err     (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Comparator: combinational on guess; fault forces an illegal less+equal answer.
  assign less    = fault ? 1'b1 : (guess <  target);
  assign equal   = fault ? 1'b1 : (guess == target);
  assign greater = fault ? 1'b0 : (guess >  target);

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Number of probes: one per bit from the MSB down to the lowest set bit.
  function automatic int exp_probes(input int t);
    int k;
    if (t == 0) return WIDTH;
    k = 0;
    while (((t >> k) & 1) == 0) k++;
    return WIDTH - k;
  endfunction

  // j-th probe (1-based) tests bit p = WIDTH-j: target's bits above p, plus bit p.
  function automatic int exp_guess(input int t, input int j);
    int p;
    p = WIDTH - j;
    return ((t >> (p + 1)) << (p + 1)) | (1 << p);
  endfunction

  // Launch one search from a negedge and follow it to done.
  // keep=1 leaves start high so the next search begins right after done.
  task automatic do_search(input int t, input bit keep);
    int  n;
    bit  fin;
    n      = 0;
    fin    = 1'b0;
    target = WIDTH'(t);
    start  = 1'b1;
    for (int c = 0; c < 2 * WIDTH + 2 && !fin; c++) begin
      @(negedge clk);
      if (!keep) start = 1'b0;
      if (done) begin
        fin = 1'b1;
      end else begin
        n++;
        check($sformatf("t%0d_busy_p%0d", t, n), 32'(busy), 1);
        check($sformatf("t%0d_guess_p%0d", t, n), 32'(guess), exp_guess(t, n));
      end
    end
    check($sformatf("t%0d_finished", t), 32'(fin), 1);
    check($sformatf("t%0d_probes", t), n, exp_probes(t));
    check($sformatf("t%0d_result", t), 32'(result), t);
    check($sformatf("t%0d_err", t), 32'(err), 0);
    check($sformatf("t%0d_busy_at_done", t), 32'(busy), 0);
  endtask

  initial begin
    rst_n  = 1'b0;
    start  = 1'b0;
    target = '0;
    fault  = 1'b0;

    // Reset state
    #12;
    check("rst_busy",   32'(busy),   0);
    check("rst_done",   32'(done),   0);
    check("rst_guess",  32'(guess),  0);
    check("rst_result", 32'(result), 0);
    check("rst_err",    32'(err),    0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("idle_busy", 32'(busy), 0);

    // Directed searches
    do_search(12, 1'b0);
    do_search(10, 1'b0);
    do_search(0,  1'b0);
    do_search(15, 1'b0);
    // done is a single pulse and guess holds its last probe in IDLE
    @(negedge clk);
    check("done_pulse_drop", 32'(done),   0);
    check("guess_hold",      32'(guess),  15);
    check("result_hold",     32'(result), 15);

    // Exhaustive, back-to-back with start held high (start while busy ignored)
    for (int t = 0; t < (1 << WIDTH); t++) do_search(t, 1'b1);
    start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("idle_after_b2b", 32'(busy), 0);

    // Randomized targets with random idle gaps
    for (int i = 0; i < 20; i++) begin
      repeat ($urandom_range(0, 3)) @(negedge clk);
      do_search(int'($urandom_range(0, (1 << WIDTH) - 1)), 1'b0);
    end

    // Fault: illegal flags on the second probe of target 10
    target = 4'd10;
    start  = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("flt_p1_guess", 32'(guess), 8);
    @(negedge clk);
    check("flt_p2_guess", 32'(guess), 12);
    fault = 1'b1;
    @(negedge clk);
    fault = 1'b0;
    check("flt_done",   32'(done),   1);
    check("flt_err",    32'(err),    1);
    check("flt_result", 32'(result), 0);
    check("flt_busy",   32'(busy),   0);
    @(negedge clk);
    check("flt_err_held",  32'(err),  1);
    check("flt_done_drop", 32'(done), 0);
    do_search(5, 1'b0);

    // Reset mid-search during probe 2
    target = 4'd10;
    start  = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    check("rm_p2_busy", 32'(busy), 1);
    #1 rst_n = 1'b0;
    #1;
    check("rm_busy",   32'(busy),   0);
    check("rm_guess",  32'(guess),  0);
    check("rm_result", 32'(result), 0);
    check("rm_done",   32'(done),   0);
    @(negedge clk);
    check("rm_done_in_rst", 32'(done), 0);
    rst_n = 1'b1;
    @(negedge clk);
    check("rm_no_done_after", 32'(done), 0);
    check("rm_idle_after",    32'(busy), 0);
    do_search(9, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Global time limit so the bench always terminates.
  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule
